// File: rtl/pq_cmd_sequencer.sv
// Command sequencer in front of the BRAM tree priority queue.
// Buffers enqueue/dequeue/replace commands in a small FIFO, issues one
// single-cycle strobe per command to the tree, keeps successive strobes
// OP_GAP cycles apart, and returns removed root values or drop notices
// on a valid/ready response port in command order.
module pq_cmd_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int OP_GAP     = 25
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            s_op,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  t_wrt,
    output logic                  t_read,
    output logic [DATA_WIDTH-1:0] t_data,
    input  logic                  t_full,
    input  logic                  t_empty,
    input  logic [DATA_WIDTH-1:0] t_root,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_drop,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(OP_GAP + 1);
    // The ISSUE cycle and the IDLE cycle that precede the next strobe are
    // part of the spacing, so the counter only has to cover the rest.
    localparam logic [GW-1:0] GAP_LOAD = GW'(OP_GAP - 2);

    localparam logic [1:0] OP_ENQ = 2'd0;
    localparam logic [1:0] OP_DEQ = 2'd1;
    localparam logic [1:0] OP_REP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic [1:0]              op_mem_r  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   key_mem_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic [1:0]              cmd_op_r;
    logic [DATA_WIDTH-1:0]   cmd_key_r;
    logic [GW-1:0]           gap_r;
    logic                    push_s, pop_s;
    logic                    wrt_s, read_s, resp_s, drop_s;

    assign s_ready = (count_r != CW'(FIFO_DEPTH));
    assign push_s  = s_valid && s_ready && !RST;
    assign busy    = (count_r != '0) || (state_r != ST_IDLE) || r_valid;

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge CLK) begin
        if (push_s) begin
            op_mem_r[wr_ptr_r]  <= s_op;
            key_mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Command register loaded with the FIFO head on the way into ISSUE
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_op_r  <= 2'd0;
            cmd_key_r <= '0;
        end else if (pop_s) begin
            cmd_op_r  <= op_mem_r[rd_ptr_r];
            cmd_key_r <= key_mem_r[rd_ptr_r];
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Next-state, FIFO pop and issue decision against the live tree flags
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        wrt_s        = 1'b0;
        read_s       = 1'b0;
        resp_s       = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != '0) && (gap_r == '0) && !r_valid) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
                case (cmd_op_r)
                    OP_ENQ: begin
                        if (!t_full) begin
                            wrt_s = 1'b1;
                        end else begin
                            resp_s = 1'b1;
                            drop_s = 1'b1;
                        end
                    end
                    OP_DEQ: begin
                        if (!t_empty) begin
                            read_s = 1'b1;
                            resp_s = 1'b1;
                        end else begin
                            resp_s = 1'b1;
                            drop_s = 1'b1;
                        end
                    end
                    OP_REP: begin
                        if (!t_empty) begin
                            wrt_s  = 1'b1;
                            read_s = 1'b1;
                            resp_s = 1'b1;
                        end else begin
                            resp_s = 1'b1;
                            drop_s = 1'b1;
                        end
                    end
                    default: begin
                        resp_s = 1'b1;
                        drop_s = 1'b1;
                    end
                endcase
            end
            ST_WAIT: begin
                // Leave as the counter reaches zero so IDLE sees gap==0
                if (gap_r <= GW'(1)) state_next_s = ST_IDLE;
                else                 state_next_s = ST_WAIT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Spacing counter: loaded by a strobe, counts down to zero
    always_ff @(posedge CLK) begin
        if (RST)                   gap_r <= '0;
        else if (wrt_s || read_s)  gap_r <= GAP_LOAD;
        else if (gap_r != '0)      gap_r <= gap_r - GW'(1);
        else                       gap_r <= gap_r;
    end

    // Registered tree strobes, held key and the response register
    always_ff @(posedge CLK) begin
        if (RST) begin
            t_wrt   <= 1'b0;
            t_read  <= 1'b0;
            t_data  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else begin
            t_wrt  <= wrt_s;
            t_read <= read_s;
            if (wrt_s) t_data <= cmd_key_r;
            if (resp_s) begin
                r_valid <= 1'b1;
                r_drop  <= drop_s;
                r_data  <= drop_s ? '0 : t_root;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed bench for pq_cmd_sequencer: a table of single-command vectors
// against forced tree flags, plus hand-written multi-cycle sequences that
// run against a small max-priority-queue model of a depth-7 tree.
module tb_pq_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_op;
    logic [15:0] s_data;
    logic        t_wrt, t_read;
    logic [15:0] t_data;
    logic        t_full, t_empty;
    logic [15:0] t_root;
    logic        r_valid, r_ready;
    logic [15:0] r_data;
    logic        r_drop;
    logic        busy;

    pq_cmd_sequencer #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .OP_GAP(25)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
        .t_wrt(t_wrt), .t_read(t_read), .t_data(t_data),
        .t_full(t_full), .t_empty(t_empty), .t_root(t_root),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_drop(r_drop),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // observation counters
    int wrt_cnt = 0, read_cnt = 0, rep_cnt = 0, strobe_cnt = 0;
    int resp_cnt = 0, drop_cnt = 0, resp_cyc = 0;
    logic [15:0] last_rdata = 16'd0;
    logic        last_rdrop = 1'b0;
    logic [15:0] last_tdata = 16'd0;
    int strobe_cyc[$];

    // tree model / forced tree flags
    logic        use_model = 1'b0;
    logic        f_full = 1'b0, f_empty = 1'b1;
    logic [15:0] f_root = 16'd0;
    int          m_cnt = 0;
    logic [15:0] m_key [8];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] key;
        logic        full;
        logic        empty;
        logic [15:0] root;
        int          exp_wrt;
        int          exp_read;
        int          exp_resp;
        logic [15:0] exp_rdata;
        logic        exp_drop;
        logic [15:0] exp_tdata;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cycle);
    endtask

    function automatic logic [15:0] m_max();
        logic [15:0] mx = 16'd0;
        for (int i = 0; i < m_cnt; i++) if (m_key[i] > mx) mx = m_key[i];
        return mx;
    endfunction

    task automatic m_remove_max();
        int idx = 0;
        if (m_cnt > 0) begin
            for (int i = 1; i < m_cnt; i++) if (m_key[i] > m_key[idx]) idx = i;
            m_key[idx] = m_key[m_cnt-1];
            m_cnt--;
        end
    endtask

    task automatic m_insert(input logic [15:0] k);
        if (m_cnt < 7) begin
            m_key[m_cnt] = k;
            m_cnt++;
        end
    endtask

    task automatic drive_tree();
        if (use_model) begin
            t_full  = (m_cnt >= 7);
            t_empty = (m_cnt == 0);
            t_root  = m_max();
        end else begin
            t_full  = f_full;
            t_empty = f_empty;
            t_root  = f_root;
        end
    endtask

    // one clock: note the handshake due at the coming edge, then observe at negedge
    task automatic cyc();
        logic        hs;
        logic [15:0] hd;
        logic        hp;
        hs = r_valid && r_ready;
        hd = r_data;
        hp = r_drop;
        @(negedge CLK);
        cycle++;
        if (hs) begin
            resp_cnt++;
            last_rdata = hd;
            last_rdrop = hp;
            resp_cyc   = cycle;
            if (hp) drop_cnt++;
        end
        if (t_wrt || t_read) begin
            strobe_cnt++;
            strobe_cyc.push_back(cycle);
            if (t_wrt) begin wrt_cnt++; last_tdata = t_data; end
            if (t_read) read_cnt++;
            if (t_wrt && t_read) rep_cnt++;
            if (t_wrt && t_read) begin m_remove_max(); m_insert(t_data); end
            else if (t_wrt)      m_insert(t_data);
            else                 m_remove_max();
        end
        drive_tree();
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] key);
        int g = 0;
        s_valid = 1'b1; s_op = op; s_data = key;
        while (!s_ready && g < 500) begin cyc(); g++; end
        if (!s_ready) timeout("send_accept");
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while (busy && g < limit) begin cyc(); g++; end
        if (busy) timeout("wait_idle");
    endtask

    task automatic wait_strobes(input int target, input int limit);
        int g = 0;
        while (strobe_cnt < target && g < limit) begin cyc(); g++; end
        if (strobe_cnt < target) timeout("wait_strobe");
    endtask

    task automatic wait_rvalid(input int limit);
        int g = 0;
        while (!r_valid && g < limit) begin cyc(); g++; end
        if (!r_valid) timeout("wait_rvalid");
    endtask

    initial begin
        int w0, r0, p0, s0, d0, q0, bad;
        //            op    key       full  empty root      wrt rd rsp rdata     drop  tdata
        vecs[0] = '{2'd0, 16'h1234, 1'b0, 1'b1, 16'h0000, 1, 0, 0, 16'h0000, 1'b0, 16'h1234};
        vecs[1] = '{2'd0, 16'h00AA, 1'b1, 1'b0, 16'h0300, 0, 0, 1, 16'h0000, 1'b1, 16'h1234};
        vecs[2] = '{2'd1, 16'h5555, 1'b0, 1'b0, 16'h0777, 0, 1, 1, 16'h0777, 1'b0, 16'h1234};
        vecs[3] = '{2'd1, 16'h0000, 1'b0, 1'b1, 16'h0000, 0, 0, 1, 16'h0000, 1'b1, 16'h1234};
        vecs[4] = '{2'd2, 16'h0042, 1'b1, 1'b0, 16'h0500, 1, 1, 1, 16'h0500, 1'b0, 16'h0042};
        vecs[5] = '{2'd2, 16'h0043, 1'b0, 1'b1, 16'h0000, 0, 0, 1, 16'h0000, 1'b1, 16'h0042};
        vecs[6] = '{2'd3, 16'h1111, 1'b0, 1'b0, 16'h0900, 0, 0, 1, 16'h0000, 1'b1, 16'h0042};
        vecs[7] = '{2'd0, 16'hFFFF, 1'b0, 1'b0, 16'h0900, 1, 0, 0, 16'h0000, 1'b0, 16'hFFFF};

        RST = 1'b1; s_valid = 1'b1; s_op = 2'd0; s_data = 16'd5; r_ready = 1'b1;
        drive_tree();

        // reset held with s_valid high: nothing may be pushed
        cyc(); cyc();
        chk("rst_t_wrt", t_wrt, 1'b0);
        chk("rst_t_read", t_read, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_t_data", t_data, 16'd0);
        RST = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("rst_no_strobe", strobe_cnt, 0);
        chk("rst_no_push_busy", busy, 1'b0);

        // table of single commands against forced tree flags
        for (int i = 0; i < 8; i++) begin
            f_full = vecs[i].full; f_empty = vecs[i].empty; f_root = vecs[i].root;
            drive_tree();
            w0 = wrt_cnt; r0 = read_cnt; p0 = resp_cnt;
            send(vecs[i].op, vecs[i].key);
            wait_idle(100);
            chk($sformatf("vec%0d_wrt", i), wrt_cnt - w0, vecs[i].exp_wrt);
            chk($sformatf("vec%0d_read", i), read_cnt - r0, vecs[i].exp_read);
            chk($sformatf("vec%0d_resp", i), resp_cnt - p0, vecs[i].exp_resp);
            if (vecs[i].exp_resp != 0) begin
                chk($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rdrop", i), last_rdrop, vecs[i].exp_drop);
            end
            chk($sformatf("vec%0d_tdata", i), t_data, vecs[i].exp_tdata);
        end

        // ENQ 5, ENQ 9, DEQ into the tree model: strobes 25 apart, DEQ returns 9
        use_model = 1'b1; m_cnt = 0; drive_tree();
        strobe_cyc.delete();
        p0 = resp_cnt;
        send(2'd0, 16'd5); send(2'd0, 16'd9); send(2'd1, 16'd0);
        wait_idle(200);
        chk("seq_strobes", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            chk("seq_gap1", strobe_cyc[1] - strobe_cyc[0], 25);
            chk("seq_gap2", strobe_cyc[2] - strobe_cyc[1], 25);
        end
        chk("seq_resp", resp_cnt - p0, 1);
        chk("seq_rdata", last_rdata, 16'd9);
        chk("seq_rdrop", last_rdrop, 1'b0);

        // DEQ on an empty tree: drop, next command issues 2 cycles after handshake
        m_cnt = 0; drive_tree();
        r_ready = 1'b0; s0 = strobe_cnt;
        send(2'd1, 16'd0);
        wait_rvalid(20);
        chk("emp_rdrop", r_drop, 1'b1);
        chk("emp_rdata", r_data, 16'd0);
        send(2'd0, 16'd7);
        for (int i = 0; i < 5; i++) cyc();
        chk("emp_no_strobe", strobe_cnt - s0, 0);
        r_ready = 1'b1;
        cyc();
        wait_strobes(s0 + 1, 10);
        if (strobe_cyc.size() > 0) chk("emp_issue_lat", strobe_cyc[strobe_cyc.size()-1] - resp_cyc, 2);
        wait_idle(100);

        // FIFO fill behind a pending response, then drain into a tree that fills at 7
        m_cnt = 0; drive_tree();
        r_ready = 1'b0; w0 = wrt_cnt; d0 = drop_cnt; q0 = resp_cnt;
        send(2'd3, 16'd0);
        wait_rvalid(20);
        for (int i = 0; i < 8; i++) send(2'd0, 16'(10 + i));
        chk("full_s_ready", s_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        s_valid = 1'b1; s_op = 2'd0; s_data = 16'd99;
        for (int i = 0; i < 5; i++) cyc();
        chk("full_hold_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        strobe_cyc.delete();
        r_ready = 1'b1;
        wait_idle(400);
        chk("full_wrt", wrt_cnt - w0, 7);
        chk("full_drops", drop_cnt - d0, 2);
        chk("full_resps", resp_cnt - q0, 2);
        chk("full_last_rdrop", last_rdrop, 1'b1);
        chk("full_last_rdata", last_rdata, 16'd0);
        chk("full_last_tdata", last_tdata, 16'd16);
        bad = 0;
        for (int i = 1; i < strobe_cyc.size(); i++) if (strobe_cyc[i] - strobe_cyc[i-1] != 25) bad++;
        chk("full_spacing", bad, 0);

        // REP 3 on root 100 with the response held off for 40 cycles
        m_cnt = 0; m_insert(16'd100); drive_tree();
        r_ready = 1'b0; s0 = strobe_cnt; p0 = rep_cnt;
        send(2'd2, 16'd3);
        wait_rvalid(20);
        chk("rep_strobe", rep_cnt - p0, 1);
        chk("rep_rdata", r_data, 16'd100);
        chk("rep_rdrop", r_drop, 1'b0);
        send(2'd0, 16'd50);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!r_valid || r_data !== 16'd100) bad++;
        end
        chk("rep_stable", bad, 0);
        chk("rep_no_strobe", strobe_cnt - s0, 1);
        r_ready = 1'b1;
        cyc();
        chk("rep_taken", last_rdata, 16'd100);
        wait_strobes(s0 + 2, 10);
        chk("rep_next_tdata", last_tdata, 16'd50);
        wait_idle(100);

        // reset during WAIT with 4 commands queued and a response pending
        m_cnt = 0; m_insert(16'd42); drive_tree();
        r_ready = 1'b0; s0 = strobe_cnt; p0 = resp_cnt;
        send(2'd1, 16'd0);
        for (int i = 0; i < 4; i++) send(2'd0, 16'(1 + i));
        wait_strobes(s0 + 1, 20);
        cyc(); cyc();
        chk("mid_r_valid_pre", r_valid, 1'b1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("mid_r_valid", r_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_s_ready", s_ready, 1'b1);
        r_ready = 1'b1;
        for (int i = 0; i < 60; i++) cyc();
        chk("mid_no_strobe", strobe_cnt - s0, 1);
        chk("mid_no_resp", resp_cnt - p0, 0);
        send(2'd0, 16'd77);
        wait_strobes(s0 + 2, 10);
        chk("mid_new_tdata", last_tdata, 16'd77);
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
